// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample path: widths, FIFO state encoding
// and a saturating counter helper.
package adc_pkg;

    localparam int ADC_DATA_W = 8;
    localparam int DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } fifo_state_e;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == {DROP_CNT_W{1'b1}}) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/sample_fifo_mem.sv
// Sample storage: register array with a synchronous write port and an
// asynchronous read port, kept separate so it can become an EBR later.
module sample_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/adc_sample_fifo.sv
// Elastic buffer behind the serial ADC interface: drops the first DISCARD
// strobes after enable, buffers samples first-word fall-through, and keeps
// a sticky overflow flag plus a saturating drop count for the debug LEDs.
//
// state    | meaning
// ST_IDLE  | disabled; pointers and level held at 0, writes ignored
// ST_PRIME | counting off misaligned samples after enable; nothing stored
// ST_RUN   | normal capture and handshake
module adc_sample_fifo
    import adc_pkg::*;
#(
    parameter int DATA_W    = ADC_DATA_W,
    parameter int DEPTH     = 16,
    parameter int AFULL_LVL = 12,
    parameter int DISCARD   = 4,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                  i_sys_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_wr_valid,
    input  logic [DATA_W-1:0]     i_wr_data,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_rd_ready,
    output logic [AW:0]           o_level,
    output logic                  o_almost_full,
    output logic                  o_overflow,
    output logic [DROP_CNT_W-1:0] o_drop_cnt,
    input  logic                  i_clr
);

    localparam logic [AW:0] LVL_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AFULL = (AW+1)'(AFULL_LVL);

    fifo_state_e           r_state;
    logic [7:0]            r_disc_cnt;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW:0]           r_level;
    logic                  r_afull;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_run;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [AW:0]           w_level_nxt;

    assign w_run  = (r_state == ST_RUN) && i_en;
    assign w_full = (r_level == LVL_FULL);
    assign w_pop  = (r_level != '0) && i_rd_ready;
    assign w_push = w_run && i_wr_valid && (!w_full || w_pop);
    assign w_drop = w_run && i_wr_valid && w_full && !w_pop;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop)      w_level_nxt = r_level + (AW+1)'(1);
        else if (!w_push && w_pop) w_level_nxt = r_level - (AW+1)'(1);
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_disc_cnt <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_afull    <= 1'b0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            // Drop bookkeeping is independent of the flush; a drop beats clr.
            if (w_drop) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= i_clr ? DROP_CNT_W'(1) : sat_inc(r_drop_cnt);
            end else if (i_clr) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (i_en) begin
                        r_disc_cnt <= 8'(DISCARD);
                        r_state    <= (DISCARD == 0) ? ST_RUN : ST_PRIME;
                    end
                end
                ST_PRIME, ST_RUN: begin
                    if (!i_en) begin
                        r_state <= ST_IDLE;
                        r_wptr  <= '0;
                        r_rptr  <= '0;
                        r_level <= '0;
                        r_afull <= 1'b0;
                    end else if (r_state == ST_PRIME) begin
                        if (i_wr_valid) begin
                            r_disc_cnt <= r_disc_cnt - 8'd1;
                            if (r_disc_cnt == 8'd1) r_state <= ST_RUN;
                        end
                    end else begin
                        if (w_push) r_wptr <= r_wptr + AW'(1);
                        if (w_pop)  r_rptr <= r_rptr + AW'(1);
                        r_level <= w_level_nxt;
                        r_afull <= (w_level_nxt >= LVL_AFULL);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sample_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .i_clk   (i_sys_clk),
        .i_we    (w_push),
        .i_waddr (r_wptr),
        .i_wdata (i_wr_data),
        .i_raddr (r_rptr),
        .o_rdata (o_rd_data)
    );

    assign o_rd_valid    = (r_level != '0);
    assign o_level       = r_level;
    assign o_almost_full = r_afull;
    assign o_overflow    = r_overflow;
    assign o_drop_cnt    = r_drop_cnt;

endmodule
